// File: rtl/mips_int_ctrl.sv
// Vectored interrupt controller: fixed-priority arbitration, entry/ERET sequencing, EPC and status bit.
// Optional software-pending source is enabled by defining MIPS_INT_SWI_EN.
module mips_int_ctrl #(
  parameter int          NUM_IRQ    = 4,
  parameter int          ID_W       = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int          VEC_STRIDE = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  output logic [NUM_IRQ-1:0] irq_ack,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wd,
  input  logic               ie_we,
  input  logic               ie_wd,
  input  logic               eret,
  input  logic [31:0]        pc_next,
  output logic               pc_redirect,
  output logic [31:0]        pc_target,
  output logic [31:0]        epc,
  output logic               status_ie,
  output logic [ID_W-1:0]    active_id,
`ifdef MIPS_INT_SWI_EN
  input  logic               swi_we,
  input  logic               swi_wd,
`endif
  output logic               in_service
);

`ifdef MIPS_INT_SWI_EN
  localparam int NSRC = NUM_IRQ + 1;
`else
  localparam int NSRC = NUM_IRQ;
`endif

  typedef enum logic [1:0] {IDLE, TAKE, SERVICE} state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] mask;
  logic [NSRC-1:0]    pend;
  logic [ID_W-1:0]    sel;
  logic               take_ok;

  function automatic logic [ID_W-1:0] lowest_set(input logic [NSRC-1:0] v);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (v[i]) id = ID_W'(i);
    return id;
  endfunction

  function automatic logic [31:0] vector_addr(input logic [ID_W-1:0] id);
    return VEC_BASE + 32'(id) * 32'(VEC_STRIDE);
  endfunction

`ifdef MIPS_INT_SWI_EN
  logic swi_pend;

  // Software source sits above the hardware sources, so it is the lowest priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      swi_pend <= 1'b0;
    else if (swi_we)
      swi_pend <= swi_wd;
    else if (state == TAKE && active_id == ID_W'(NUM_IRQ))
      swi_pend <= 1'b0;
  end

  assign pend = {swi_pend, irq_req & mask};
`else
  assign pend = irq_req & mask;
`endif

  assign sel     = lowest_set(pend);
  assign take_ok = status_ie && (|pend) && !(ie_we && !ie_wd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      status_ie <= 1'b0;
      mask      <= '1;
      epc       <= '0;
      active_id <= '0;
    end else begin
      if (mask_we) mask <= mask_wd;
      case (state)
        IDLE: begin
          if (ie_we) status_ie <= ie_wd;
          if (take_ok) begin
            active_id <= sel;
            state     <= TAKE;
          end
        end
        TAKE: begin
          // The instruction executing now completes; its successor is the return address.
          epc       <= pc_next;
          status_ie <= 1'b0;
          state     <= SERVICE;
        end
        SERVICE: begin
          if (eret) begin
            status_ie <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pc_redirect = 1'b0;
    pc_target   = '0;
    irq_ack     = '0;
    if (state == TAKE) begin
      pc_redirect = 1'b1;
      pc_target   = vector_addr(active_id);
      // Shifting past the top bit leaves the ack clear for the software source.
      irq_ack     = NUM_IRQ'(1) << active_id;
    end else if (state == SERVICE && eret) begin
      pc_redirect = 1'b1;
      pc_target   = epc;
    end
  end

  assign in_service = (state != IDLE);

endmodule

// File: doc/mips_int_ctrl.md
Name: mips_int_ctrl

Overview:
Vectored interrupt controller for the single-cycle MIPS core. It arbitrates among NUM_IRQ level-sensitive hardware requesters by fixed priority and owns the global interrupt-enable status bit. It sequences interrupt entry: PC redirect to the vector, EPC capture and acknowledge pulse. It also sequences return on ERET. It sits beside the controller and drives the datapath's PC-select override and EPC register.

Parameters:
NUM_IRQ, 4, number of hardware requesters (1..7)
ID_W, 3, width of source id
VEC_BASE, 32'h00000100, byte address of vector 0
VEC_STRIDE, 8, byte spacing between vectors (multiple of 4)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
irq_req  in  NUM_IRQ  level requests; bit 0 is highest priority
irq_ack  out  NUM_IRQ  one-cycle one-hot acknowledge of the taken source
mask_we  in  1  write enable for the mask register
mask_wd  in  NUM_IRQ  new mask value; 1 = source enabled
ie_we  in  1  write enable for the status bit (from status_write decode)
ie_wd  in  1  new status-bit value
eret  in  1  decoded return-from-interrupt instruction
pc_next  in  32  datapath next PC before any interrupt override
pc_redirect  out  1  override datapath pcnext this cycle
pc_target  out  32  PC to load when pc_redirect=1
epc  out  32  saved return address
status_ie  out  1  global interrupt enable
active_id  out  ID_W  id of the source in service (cause)
in_service  out  1  high from TAKE through the ERET cycle

Behaviour:
- Reset values: state IDLE; status_ie=0; mask=all 1s; epc=0; active_id=0; irq_ack=0; pc_redirect=0; pc_target=0.
- pend = irq_req & mask. sel = lowest set index of pend.
- IDLE:
  - Writes: mask_we updates mask; ie_we updates status_ie.
  - If status_ie=1, pend!=0 and not (ie_we & ~ie_wd): at the edge, latch active_id=sel and go to TAKE. An ie clear in the same cycle wins and no interrupt is taken.
  - eret in IDLE is a no-op: no redirect, no state change.
- TAKE (exactly one cycle):
  - Outputs: pc_redirect=1; pc_target=VEC_BASE+active_id*VEC_STRIDE (32-bit, wraps mod 2^32); irq_ack[active_id]=1.
  - At the edge: epc<=pc_next, status_ie<=0, go to SERVICE. This means the instruction executing in TAKE completes normally.
  - The latched id is used even if irq_req or mask change during TAKE. ie_we and eret are ignored; mask_we is honoured.
- SERVICE:
  - Requests are ignored; no nesting. mask_we is honoured; ie_we is ignored.
  - On eret: pc_redirect=1 and pc_target=epc combinationally in the same cycle. At the edge: status_ie<=1, go to IDLE. in_service stays high through the eret cycle.
- Entry latency: a request visible at edge n is redirected during cycle n+1.
- After ERET, at least one instruction at epc executes before the next TAKE, because IDLE sampling adds a cycle.
- irq_ack is a pulse only; requesters must drop irq_req in their handler, or the request is retaken after ERET.
- Reset mid-operation (TAKE or SERVICE) returns to IDLE with reset values; any pending ack is discarded.
- pc_redirect=0 and pc_target=0 in all other cycles.

Optional Feature:
MIPS_INT_SWI_EN
- Defined: adds ports swi_we (in, 1) and swi_wd (in, 1) writing a software-pending bit, writable in any state.
  - The bit acts as the lowest-priority source with id NUM_IRQ, enabled by the status bit only (no mask bit).
  - Vector is VEC_BASE+NUM_IRQ*VEC_STRIDE.
  - The bit is cleared by hardware at the TAKE edge; a simultaneous swi_we with swi_wd=1 re-sets it.
  - swi is not reflected on irq_ack.
- Undefined: no ports, no state; behaviour is exactly as above.

Test Plan:
- Reset, then ie=0, irq_req=4'b0001 for 5 cycles -> pc_redirect stays 0; status_ie=0, epc=0, irq_ack=0.
- ie_we=1/ie_wd=1; irq_req=4'b0100 at edge n; pc_next=0x44 in cycle n+1 -> cycle n+1: pc_redirect=1, pc_target=0x110, irq_ack=4'b0100; after the edge epc=0x44, status_ie=0, active_id=2.
- ie=1, irq_req=4'b1010 -> target 0x108, irq_ack=4'b0010, active_id=1.
- In SERVICE with epc=0x44, irq_req=4'b0001 held -> no redirect. Assert eret -> same cycle target=0x44; next cycle status_ie=1. The following cycle is TAKE with target 0x100.
- mask_wd=4'b1110, irq_req=4'b0001 -> no take. Then mask all 1s with ie_we/ie_wd=0 in the request cycle -> no take and status_ie=0.
- Reset asserted during SERVICE -> immediate IDLE, status_ie=0, epc=0, in_service=0. With MIPS_INT_SWI_EN: swi set, ie=1, no hw requests -> target 0x120; swi bit cleared after TAKE.
